// File: rtl/dpr_sync_be.sv
// dpr_sync_be: dual-port synchronous RAM with byte-lane write enables, 1 or 2 cycle read latency and collision bypass
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low; clears the read pipeline, not the memory
//   din        write data
//   addr_wr    write address; addresses >= MEM_DEPTH are ignored
//   wr_en      write request
//   wr_be      byte-lane write enables, bit i covers din[i*BYTE_W +: BYTE_W]
//   addr_rd    read address; addresses >= MEM_DEPTH read as zero
//   rd_en      read request
//   blk_select block enable gating both ports; in-flight reads still drain
//   dout       read data, holds its last value between reads
//   dout_valid one-cycle strobe per completed read
module dpr_sync_be #(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_SIZE  = 10,
  parameter int BYTE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1,
  localparam int NB        = MEM_WIDTH / BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic [ADDR_SIZE-1:0] addr_wr,
  input  logic                 wr_en,
  input  logic [NB-1:0]        wr_be,
  input  logic [ADDR_SIZE-1:0] addr_rd,
  input  logic                 rd_en,
  input  logic                 blk_select,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid
);
  // one extra bit so MEM_DEPTH == 2**ADDR_SIZE still compares correctly
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic                 wr_ok, rd_ok, rd_in, v1;
  logic [MEM_WIDTH-1:0] old_word, rd_word, d1;
  assign wr_ok    = rst && blk_select && wr_en && ({1'b0, addr_wr} < DEPTH);
  assign rd_ok    = blk_select && rd_en;
  assign rd_in    = {1'b0, addr_rd} < DEPTH;
  assign old_word = rd_in ? mem[addr_rd] : '0;
  // a same-cycle write to the read address forwards its enabled lanes when bypass is on
  always_comb begin
    rd_word = old_word;
    for (int i = 0; i < NB; i++)
      if (BYPASS != 0 && wr_ok && addr_wr == addr_rd && wr_be[i])
        rd_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk)
    if (wr_ok)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[addr_wr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) d1 <= rd_word;
    end
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                 v2;
      logic [MEM_WIDTH-1:0] d2;
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      assign dout       = d2;
      assign dout_valid = v2;
    end else begin : g_lat1
      assign dout       = d1;
      assign dout_valid = v1;
    end
  endgenerate
endmodule

// File: tb/tb_dpr_sync_be.sv
// tb_dpr_sync_be: checks a latency-1 bypass build and a latency-2 no-bypass shallow build against a word-level model
module tb_dpr_sync_be;
  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] din = '0;
  logic [9:0]  addr_wr = '0, addr_rd = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, blk_select = 1'b1;
  logic [1:0]  wr_be = '0;
  logic [15:0] dout_a, dout_b;
  logic        dv_a, dv_b;
  int          errors = 0, checks = 0;
  logic [15:0] m [2][1024];
  int          depth [2] = '{1024, 1000};
  bit          byp [2] = '{1'b1, 1'b0};
  logic [15:0] expd [2] = '{16'h0, 16'h0};
  bit          expv [2] = '{1'b0, 1'b0};
  logic [15:0] pd = '0;
  bit          pv = 1'b0;
  always #5 clk = ~clk;
  dpr_sync_be u_a (
    .clk(clk), .rst(rst), .din(din), .addr_wr(addr_wr), .wr_en(wr_en), .wr_be(wr_be),
    .addr_rd(addr_rd), .rd_en(rd_en), .blk_select(blk_select), .dout(dout_a), .dout_valid(dv_a)
  );
  dpr_sync_be #(.MEM_DEPTH(1000), .RD_LATENCY(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .din(din), .addr_wr(addr_wr), .wr_en(wr_en), .wr_be(wr_be),
    .addr_rd(addr_rd), .rd_en(rd_en), .blk_select(blk_select), .dout(dout_b), .dout_valid(dv_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input bit we, input bit [1:0] be, input bit [9:0] aw, input bit [15:0] d,
                      input bit re, input bit [9:0] ar, input bit bs = 1'b1);
    logic [15:0] res [2];
    bit          v [2];
    bit          wok;
    din = d; addr_wr = aw; wr_en = we; wr_be = be; addr_rd = ar; rd_en = re; blk_select = bs;
    for (int k = 0; k < 2; k++) begin
      wok    = bs && we && (int'(aw) < depth[k]);
      v[k]   = bs && re;
      res[k] = (int'(ar) < depth[k]) ? m[k][ar] : 16'h0;
      if (wok)
        for (int i = 0; i < 2; i++)
          if (be[i]) begin
            if (v[k] && byp[k] && aw == ar) res[k][i*8 +: 8] = d[i*8 +: 8];
            m[k][aw][i*8 +: 8] = d[i*8 +: 8];
          end
    end
    @(posedge clk);
    expv[0] = v[0];
    if (v[0]) expd[0] = res[0];
    expv[1] = pv;
    if (pv) expd[1] = pd;
    pv = v[1];
    pd = res[1];
    @(negedge clk);
    check("model_dout_a", dout_a, expd[0]);
    check("model_valid_a", dv_a, expv[0]);
    check("model_dout_b", dout_b, expd[1]);
    check("model_valid_b", dv_b, expv[1]);
  endtask
  task automatic idle();
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b0, 10'd0);
  endtask
  function automatic bit [9:0] pick();
    return ($urandom % 8 == 0) ? 10'(1000 + $urandom % 24) : 10'($urandom % 16);
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout_a", dout_a, 16'h0);
    check("rst_valid_a", dv_a, 1'b0);
    check("rst_dout_b", dout_b, 16'h0);
    check("rst_valid_b", dv_b, 1'b0);
    rst = 1'b1;
    for (int a = 0; a < 1024; a++) step(1'b1, 2'b11, 10'(a), 16'($urandom), 1'b0, 10'd0);
    step(1'b1, 2'b11, 10'd5, 16'hABCD, 1'b0, 10'd0);
    step(1'b1, 2'b01, 10'd5, 16'h1234, 1'b0, 10'd0);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd5);
    check("byte_dout_a", dout_a, 16'hAB34);
    check("byte_valid_a", dv_a, 1'b1);
    idle();
    check("byte_dout_b", dout_b, 16'hAB34);
    check("byte_valid_b", dv_b, 1'b1);
    step(1'b1, 2'b11, 10'd1, 16'h0011, 1'b0, 10'd0);
    step(1'b1, 2'b11, 10'd2, 16'h0022, 1'b0, 10'd0);
    step(1'b1, 2'b11, 10'd3, 16'h0033, 1'b0, 10'd0);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd1);
    check("lat_n1_valid_b", dv_b, 1'b0);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd2);
    check("lat_n2_dout_b", dout_b, 16'h0011);
    check("lat_n2_valid_b", dv_b, 1'b1);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd3);
    check("lat_n3_dout_b", dout_b, 16'h0022);
    check("lat_n3_valid_b", dv_b, 1'b1);
    idle();
    check("lat_n4_dout_b", dout_b, 16'h0033);
    check("lat_n4_valid_b", dv_b, 1'b1);
    idle();
    check("lat_n5_valid_b", dv_b, 1'b0);
    check("lat_hold_dout_b", dout_b, 16'h0033);
    step(1'b1, 2'b11, 10'd7, 16'h5555, 1'b0, 10'd0);
    step(1'b1, 2'b10, 10'd7, 16'hAAAA, 1'b1, 10'd7);
    check("coll_bypass_a", dout_a, 16'hAA55);
    idle();
    check("coll_old_b", dout_b, 16'h5555);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd7);
    check("coll_after_a", dout_a, 16'hAA55);
    idle();
    check("coll_after_b", dout_b, 16'hAA55);
    step(1'b1, 2'b11, 10'd9, 16'h9999, 1'b0, 10'd0);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd9);
    idle();
    step(1'b1, 2'b11, 10'd9, 16'h1111, 1'b1, 10'd9, 1'b0);
    check("blk_valid_a", dv_a, 1'b0);
    check("blk_hold_a", dout_a, 16'h9999);
    idle();
    check("blk_valid_b", dv_b, 1'b0);
    check("blk_hold_b", dout_b, 16'h9999);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd9);
    check("blk_mem_a", dout_a, 16'h9999);
    idle();
    check("blk_mem_b", dout_b, 16'h9999);
    step(1'b1, 2'b11, 10'd1010, 16'hBEEF, 1'b1, 10'd1010);
    idle();
    check("range_dout_b", dout_b, 16'h0);
    check("range_valid_b", dv_b, 1'b1);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd5);
    rst = 1'b0;
    #1;
    check("midrst_dout_a", dout_a, 16'h0);
    check("midrst_valid_a", dv_a, 1'b0);
    check("midrst_dout_b", dout_b, 16'h0);
    check("midrst_valid_b", dv_b, 1'b0);
    expd = '{16'h0, 16'h0};
    expv = '{1'b0, 1'b0};
    pv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    check("midrst_after_valid_b", dv_b, 1'b0);
    idle();
    check("midrst_after2_valid_b", dv_b, 1'b0);
    step(1'b0, 2'b00, 10'd0, 16'h0, 1'b1, 10'd5);
    check("midrst_mem_a", dout_a, 16'hAB34);
    idle();
    check("midrst_mem_b", dout_b, 16'hAB34);
    repeat (600)
      step(1'($urandom), 2'($urandom), pick(), 16'($urandom), 1'($urandom), pick(), $urandom % 4 != 0);
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpr_sync_be.md
Name: dpr_sync_be

Overview:
Parametrised dual-port synchronous RAM with one write port and one read port. It adds per-byte write enables, a selectable read latency of 1 or 2 cycles, a write-to-read collision bypass and a read-valid strobe. It is the general-purpose storage macro for FIFOs, line buffers and register banks, and is gated by a block-select like the existing memories.

Parameters:
MEM_WIDTH, 16, data word width in bits; must be an integer multiple of BYTE_W
MEM_DEPTH, 1024, number of words; must be <= 2**ADDR_SIZE
ADDR_SIZE, 10, address width in bits
BYTE_W, 8, bits per write-enable lane; NB = MEM_WIDTH/BYTE_W lanes
RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2
BYPASS, 1, collision policy: 1 = read returns newly written data, 0 = read returns old data

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
din  input  MEM_WIDTH  write data
addr_wr  input  ADDR_SIZE  write address
wr_en  input  1  write request
wr_be  input  NB  byte-lane write enables; bit i covers din[i*BYTE_W +: BYTE_W]
addr_rd  input  ADDR_SIZE  read address
rd_en  input  1  read request
blk_select  input  1  block enable; gates both ports
dout  output  MEM_WIDTH  read data
dout_valid  output  1  one-cycle strobe: dout carries data for a read issued RD_LATENCY cycles earlier

Behaviour:
- Reset (rst=0, asynchronous): dout=0, dout_valid=0, all read-pipeline stages cleared. Memory contents are not cleared.
- Reset asserted mid-read: in-flight reads are dropped. No dout_valid is produced for them after release.
- Write: at posedge clk with rst=1, blk_select=1, wr_en=1 and addr_wr<MEM_DEPTH, each lane i with wr_be[i]=1 is written. Lanes with wr_be[i]=0 keep their value.
  - wr_be all zero means no change.
  - addr_wr>=MEM_DEPTH means the write is ignored.
- Read issue: at posedge clk with blk_select=1 and rd_en=1, addr_rd is sampled.
  - addr_rd>=MEM_DEPTH: the read still completes and returns 0.
- RD_LATENCY=1: dout and dout_valid update on the same edge the read issues. Data is visible in cycle N+1 for a read issued in cycle N.
- RD_LATENCY=2: stage 1 registers the data and a valid bit. Stage 2 copies stage 1 on the next edge. dout is visible in cycle N+2.
  - Back-to-back reads every cycle give one result per cycle, in order.
- dout_valid is high for exactly one cycle per issued read. dout holds its last value when no read completes; it is not cleared to 0.
- blk_select=0: no write, no read issue. The pipeline still drains reads already in flight.
- Collision: same cycle, write and read both enabled, addr_wr==addr_rd, address in range.
  - BYPASS=1: returned word is din on lanes with wr_be set and the old memory value elsewhere.
  - BYPASS=0: returned word is the entire old memory value.
  - In both cases the memory is updated.
- Write then read of the same address in the next cycle always returns the new data, independent of BYPASS.
- No arithmetic. All widths are exact and parameter-derived. No X on dout after reset.

Test Plan:
- Reset: rst=0 mid-run with a 2-cycle read in flight -> dout=0 and dout_valid=0 immediately; no valid strobe after release; memory contents intact on later reads.
- Byte write: defaults; write addr 5 = 0xABCD with be=11; write addr 5 = 0x1234 with be=01; read addr 5 -> dout=0xAB34, dout_valid=1 at N+1.
- Latency: RD_LATENCY=2; reads of addr 1, 2, 3 on consecutive cycles (memory holds 0x0011, 0x0022, 0x0033) -> dout = 0x0011, 0x0022, 0x0033 at N+2, N+3, N+4 with dout_valid high 3 cycles.
- Collision: addr 7 holds 0x5555; write 0xAAAA with be=10 and read addr 7 in the same cycle -> BYPASS=1 gives 0xAA55, BYPASS=0 gives 0x5555; a later read gives 0xAA55 in both builds.
- Block select: blk_select=0 with wr_en=1 and rd_en=1 at addr 9 -> memory unchanged, no dout_valid, dout holds its previous value.
- Range: MEM_DEPTH=1000; write and read at addr 1010 -> write ignored, read returns dout=0 with dout_valid=1.
